// File: rtl/ol_dpwm.sv
// Open-loop counter-based PWM with complementary high/low-side drives and fixed dead time.
// The on-time is shadowed and only reloaded at a period wrap or when leaving IDLE.
module ol_dpwm #(
    parameter int CNT_W    = 11,
    parameter int PERIOD   = 1000,
    parameter int DEADTIME = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_ton,
    output logic             o_pwm_hs,
    output logic             o_pwm_ls,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_period_start,
    output logic [CNT_W-1:0] o_ton_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Comparisons are done one bit wider so ton+DEADTIME can never wrap.
    localparam logic [CNT_W:0] PER_W    = (CNT_W+1)'(PERIOD);
    localparam logic [CNT_W:0] LAST_W   = (CNT_W+1)'(PERIOD - 1);
    localparam logic [CNT_W:0] LS_END_W = (CNT_W+1)'(PERIOD - DEADTIME);
    localparam logic [CNT_W:0] DT_W     = (CNT_W+1)'(DEADTIME);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] ton_reg, ton_next;
    logic             hs_reg, hs_next;
    logic             ls_reg, ls_next;
    logic             ps_reg, ps_next;
    logic [CNT_W-1:0] ton_clamp;
    logic             at_last;

    always_comb begin
        ton_clamp = ({1'b0, i_ton} > PER_W) ? PER_W[CNT_W-1:0] : i_ton;
        at_last   = ({1'b0, cnt_reg} == LAST_W);
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ton_next   = ton_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (i_en) begin
                    state_next = RUN;
                    ton_next   = ton_clamp;
                end
            end
            RUN: begin
                if (at_last) begin
                    cnt_next = '0;
                    ton_next = ton_clamp;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
                if (!i_en) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Only the enable seen on the last count of the period decides what follows.
                if (at_last) begin
                    cnt_next = '0;
                    if (i_en) begin
                        state_next = RUN;
                        ton_next   = ton_clamp;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Drives are derived from the next-cycle counter so they line up with o_cnt.
    always_comb begin
        hs_next = (state_next == RUN) && ({1'b0, cnt_next} < {1'b0, ton_next});
        ls_next = (state_next != IDLE)
                  && ({1'b0, cnt_next} >= ({1'b0, ton_next} + DT_W))
                  && ({1'b0, cnt_next} < LS_END_W);
        ps_next = (state_next == RUN) && (cnt_next == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ton_reg   <= '0;
            hs_reg    <= 1'b0;
            ls_reg    <= 1'b0;
            ps_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ton_reg   <= ton_next;
            hs_reg    <= hs_next;
            ls_reg    <= ls_next;
            ps_reg    <= ps_next;
        end
    end

    assign o_pwm_hs       = hs_reg;
    assign o_pwm_ls       = ls_reg;
    assign o_cnt          = cnt_reg;
    assign o_period_start = ps_reg;
    assign o_ton_q        = ton_reg;

endmodule

// File: tb/tb_ol_dpwm.sv
// Bench for ol_dpwm: hand-computed per-period expectations are queued by the stimulus
// and checked by a monitor each time the counter reaches the last count of a period.
module tb_ol_dpwm;

    localparam int CNT_W = 11;
    localparam int LAST  = 999;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] ton;
    logic             pwm_hs;
    logic             pwm_ls;
    logic [CNT_W-1:0] cnt;
    logic             period_start;
    logic [CNT_W-1:0] ton_q;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int hs_n;
        int hs_first;
        int hs_last;
        int ls_n;
        int ls_first;
        int ls_last;
        int tq;
        int ps;
    } per_t;

    per_t exp_q[$];

    ol_dpwm #(.CNT_W(CNT_W), .PERIOD(1000), .DEADTIME(4)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_en           (en),
        .i_ton          (ton),
        .o_pwm_hs       (pwm_hs),
        .o_pwm_ls       (pwm_ls),
        .o_cnt          (cnt),
        .o_period_start (period_start),
        .o_ton_q        (ton_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end else begin
            $display("[TB] ok   %s = %0d", name, act);
        end
    endtask

    function automatic per_t mk(input int hn, input int hf, input int hl,
                                input int ln, input int lf, input int ll,
                                input int tq, input int ps);
        per_t p;
        p.hs_n = hn; p.hs_first = hf; p.hs_last = hl;
        p.ls_n = ln; p.ls_first = lf; p.ls_last = ll;
        p.tq = tq; p.ps = ps;
        return p;
    endfunction

    // Wait for the next negedge at which o_cnt equals v (never matches the current cycle).
    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(cnt) != v && n < 3000);
        if (int'(cnt) != v) begin
            tests++;
            fails++;
            $display("FAIL wait_cnt: o_cnt %0d never reached, last seen %0d", v, int'(cnt));
        end
    endtask

    // Monitor: accumulate one period (o_cnt 0..999) and compare at its last count.
    initial begin
        int hs_n, hs_f, hs_l, ls_n, ls_f, ls_l, ovl, ps_seen, pidx;
        per_t e;
        hs_n = 0; hs_f = -1; hs_l = -1; ls_n = 0; ls_f = -1; ls_l = -1;
        ovl = 0; ps_seen = 0; pidx = 0;
        forever begin
            @(negedge clk);
            if (cnt == '0) begin
                hs_n = 0; hs_f = -1; hs_l = -1;
                ls_n = 0; ls_f = -1; ls_l = -1;
                ovl = 0;
                ps_seen = int'(period_start);
            end
            if (pwm_hs) begin
                if (hs_n == 0) hs_f = int'(cnt);
                hs_l = int'(cnt);
                hs_n++;
            end
            if (pwm_ls) begin
                if (ls_n == 0) ls_f = int'(cnt);
                ls_l = int'(cnt);
                ls_n++;
            end
            if (pwm_hs && pwm_ls) ovl++;
            if (int'(cnt) == LAST) begin
                pidx++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL period%0d: unexpected period end, no expectation queued", pidx);
                end else begin
                    e = exp_q.pop_front();
                    $display("[TB] period %0d: hs %0d [%0d..%0d] ls %0d [%0d..%0d] ton_q %0d ps %0d",
                             pidx, hs_n, hs_f, hs_l, ls_n, ls_f, ls_l, int'(ton_q), ps_seen);
                    chk($sformatf("p%0d hs_count", pidx), hs_n, e.hs_n);
                    chk($sformatf("p%0d hs_first", pidx), hs_f, e.hs_first);
                    chk($sformatf("p%0d hs_last", pidx), hs_l, e.hs_last);
                    chk($sformatf("p%0d ls_count", pidx), ls_n, e.ls_n);
                    chk($sformatf("p%0d ls_first", pidx), ls_f, e.ls_first);
                    chk($sformatf("p%0d ls_last", pidx), ls_l, e.ls_last);
                    chk($sformatf("p%0d ton_q", pidx), int'(ton_q), e.tq);
                    chk($sformatf("p%0d period_start", pidx), ps_seen, e.ps);
                    chk($sformatf("p%0d overlap", pidx), ovl, 0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        ton = 11'd251;

        // Expected periods, in order of occurrence.
        exp_q.push_back(mk(251, 0, 250, 741, 255, 995, 251, 1));   // P1 ton 251
        exp_q.push_back(mk(251, 0, 250, 741, 255, 995, 251, 1));   // P2 ton changes mid-period
        exp_q.push_back(mk(502, 0, 501, 490, 506, 995, 502, 1));   // P3 ton 502
        exp_q.push_back(mk(0, -1, -1, 992, 4, 995, 0, 1));         // P4 ton 0
        exp_q.push_back(mk(1000, 0, 999, 0, -1, -1, 1000, 1));     // P5 ton 2047 clamped
        exp_q.push_back(mk(996, 0, 995, 0, -1, -1, 996, 1));       // P6 ton 996
        exp_q.push_back(mk(991, 0, 990, 1, 995, 995, 991, 1));     // P7 ton 991
        exp_q.push_back(mk(101, 0, 100, 741, 255, 995, 251, 1));   // P8 drain then idle
        exp_q.push_back(mk(101, 0, 100, 741, 255, 995, 251, 1));   // P9 drain, re-enabled
        exp_q.push_back(mk(251, 0, 250, 741, 255, 995, 251, 1));   // P10 after reset restart

        repeat (3) @(negedge clk);
        chk("reset o_cnt", int'(cnt), 0);
        chk("reset hs", int'(pwm_hs), 0);
        chk("reset ls", int'(pwm_ls), 0);
        chk("reset period_start", int'(period_start), 0);
        chk("reset ton_q", int'(ton_q), 0);

        rst = 1'b0;
        en  = 1'b1;
        wait_cnt(LAST);
        wait_cnt(400);
        ton = 11'd502;
        wait_cnt(LAST);
        wait_cnt(500);
        ton = 11'd0;
        wait_cnt(500);
        ton = 11'd2047;
        wait_cnt(500);
        ton = 11'd996;
        wait_cnt(500);
        ton = 11'd991;
        wait_cnt(500);
        ton = 11'd251;

        wait_cnt(100);
        en = 1'b0;
        wait_cnt(LAST);
        @(negedge clk);
        chk("idle o_cnt", int'(cnt), 0);
        chk("idle hs", int'(pwm_hs), 0);
        chk("idle ls", int'(pwm_ls), 0);
        chk("idle period_start", int'(period_start), 0);
        @(negedge clk);
        chk("idle hold o_cnt", int'(cnt), 0);

        en = 1'b1;
        wait_cnt(100);
        en = 1'b0;
        wait_cnt(500);
        en = 1'b1;

        // The resumed period is the queued P10; it is cut short by reset and never compared.
        wait_cnt(150);
        chk("pre-reset hs", int'(pwm_hs), 1);
        chk("pre-reset period_start", int'(period_start), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-reset o_cnt", int'(cnt), 0);
        chk("mid-reset hs", int'(pwm_hs), 0);
        chk("mid-reset ls", int'(pwm_ls), 0);
        chk("mid-reset ton_q", int'(ton_q), 0);
        rst = 1'b0;
        en  = 1'b1;
        @(negedge clk);
        chk("restart o_cnt", int'(cnt), 0);
        chk("restart period_start", int'(period_start), 1);
        chk("restart ton_q", int'(ton_q), 251);
        wait_cnt(LAST);
        @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
